ascensor_dispatcher: RTL and testbench

- Upstream command stage for the elevator FSM.
- Latches floor call buttons and tracks the cabin floor from floor-pass ticks and the top/bottom limit switches.
- Drives the one-hot go_up / go_down / halt commands the elevator FSM consumes, and times the door dwell.
- Service order is SCAN: keep the current direction while requests remain ahead, otherwise reverse.

---
 rtl/ascensor_dispatcher_pkg.sv | 37 +++
 rtl/ascensor_req_reg.sv | 56 +++++
 rtl/ascensor_dispatcher.sv | 191 +++++++++++++++++++
 tb/tb_ascensor_dispatcher.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascensor_dispatcher_pkg.sv
// Shared definitions for the elevator dispatcher: state encoding, direction
// constants and the SCAN direction-pick helper.
package ascensor_dispatcher_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        DOOR      = 3'd3,
        FAULT     = 3'd4
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // SCAN choice: keep the current direction while work remains ahead,
    // otherwise reverse; with nothing outstanding the cabin stays idle.
    function automatic state_e scanPick(input logic dir, input logic above, input logic below);
        state_e pick;
        pick = IDLE;
        if (dir == DIR_UP) begin
            if (above) begin
                pick = MOVE_UP;
            end else if (below) begin
                pick = MOVE_DOWN;
            end
        end else begin
            if (below) begin
                pick = MOVE_DOWN;
            end else if (above) begin
                pick = MOVE_UP;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ascensor_req_reg.sv
// Floor request register: latches call buttons, clears the served floor,
// and reports whether any request lies above or below a query floor.
module ascensor_req_reg
    import ascensor_dispatcher_pkg::*;
#(
    parameter int N_FLOORS = 8,
    parameter int FLOOR_W  = 3
) (
    input  logic                CLK,
    input  logic                RESET_L,
    input  logic [N_FLOORS-1:0] set_i,
    input  logic                clr_en_i,
    input  logic [FLOOR_W-1:0]  clr_floor_i,
    input  logic [FLOOR_W-1:0]  floor_i,
    output logic [N_FLOORS-1:0] pending_o,
    output logic                any_above_o,
    output logic                any_below_o
);

    logic [N_FLOORS-1:0] pending_q;
    logic [N_FLOORS-1:0] pending_d;

    // New calls are OR-ed in; the served floor's clear is applied last so it wins.
    always_comb begin
        pending_d = pending_q | set_i;
        if (clr_en_i) begin
            pending_d[clr_floor_i] = 1'b0;
        end
    end

    // Request flops.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Scan the registered requests strictly above and strictly below the query floor.
    always_comb begin
        any_above_o = 1'b0;
        any_below_o = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending_q[i] && (i > int'(floor_i))) begin
                any_above_o = 1'b1;
            end
            if (pending_q[i] && (i < int'(floor_i))) begin
                any_below_o = 1'b1;
            end
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/ascensor_dispatcher.sv
// Elevator command stage: tracks the cabin floor, serves latched calls in
// SCAN order and drives one-hot go_up/go_down/halt plus the door dwell.
module ascensor_dispatcher
    import ascensor_dispatcher_pkg::*;
#(
    parameter int N_FLOORS    = 8,
    parameter int FLOOR_W     = 3,
    parameter int DOOR_CYCLES = 4,
    parameter int DOOR_W      = 3
) (
    input  logic                CLK,
    input  logic                RESET_L,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic                floor_tick,
    input  logic                top_lim,
    input  logic                bott_lim,
    output logic                go_up,
    output logic                go_down,
    output logic                halt,
    output logic                door_open,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                fault
);

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);
    localparam logic [DOOR_W-1:0]  DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

    state_e              state_q, state_d;
    logic                dir_q, dir_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic [DOOR_W-1:0]   dwellCnt_q, dwellCnt_d;

    logic                goUp_q, goUp_d;
    logic                goDown_q, goDown_d;
    logic                halt_q, halt_d;
    logic                door_q, door_d;
    logic                fault_q, fault_d;

    logic [N_FLOORS-1:0] pendingVec;
    logic [N_FLOORS-1:0] pendNow;
    logic                anyAbove, anyBelow;
    logic [FLOOR_W-1:0]  nfUp, nfDown;
    logic                hitUp, hitDown;
    logic                faultCond;
    logic                clrEn;

    ascensor_req_reg #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_req (
        .CLK         (CLK),
        .RESET_L     (RESET_L),
        .set_i       (call_req),
        .clr_en_i    (clrEn),
        .clr_floor_i (floor_d),
        .floor_i     (floor_q),
        .pending_o   (pendingVec),
        .any_above_o (anyAbove),
        .any_below_o (anyBelow)
    );

    // Next floor in each direction (saturating) and whether a stop is wanted there,
    // counting a call arriving in the same cycle as the tick.
    always_comb begin
        nfUp    = (floor_q == TOP_FLOOR) ? TOP_FLOOR : floor_q + FLOOR_W'(1);
        nfDown  = (floor_q == '0) ? '0 : floor_q - FLOOR_W'(1);
        pendNow = pendingVec | call_req;
        hitUp   = pendNow[nfUp];
        hitDown = pendNow[nfDown];
        faultCond = (top_lim && bott_lim) ||
                    ((state_q == MOVE_UP) && floor_tick && top_lim) ||
                    ((state_q == MOVE_DOWN) && floor_tick && bott_lim);
    end

    // Floor tracking: ticks count only while moving; limit switches resync and win.
    always_comb begin
        floor_d = floor_q;
        if ((state_q == MOVE_UP) && floor_tick) begin
            floor_d = nfUp;
        end else if ((state_q == MOVE_DOWN) && floor_tick) begin
            floor_d = nfDown;
        end
        if (top_lim) begin
            floor_d = TOP_FLOOR;
        end
        if (bott_lim) begin
            floor_d = '0;
        end
    end

    // Next-state logic: SCAN dispatch, stop detection, dwell timing and fault capture.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (pendingVec[floor_q]) begin
                    state_d = DOOR;
                end else begin
                    state_d = scanPick(dir_q, anyAbove, anyBelow);
                end
            end
            MOVE_UP: begin
                if (top_lim) begin
                    state_d = DOOR;
                end else if (floor_tick && (hitUp || (nfUp == TOP_FLOOR))) begin
                    state_d = DOOR;
                end
            end
            MOVE_DOWN: begin
                if (bott_lim) begin
                    state_d = DOOR;
                end else if (floor_tick && (hitDown || (nfDown == '0))) begin
                    state_d = DOOR;
                end
            end
            DOOR: begin
                if (dwellCnt_q == DOOR_LAST) begin
                    state_d = scanPick(dir_q, anyAbove, anyBelow);
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
        if (faultCond) begin
            state_d = FAULT;
        end
        if (state_d == MOVE_UP) begin
            dir_d = DIR_UP;
        end else if (state_d == MOVE_DOWN) begin
            dir_d = DIR_DOWN;
        end
        dwellCnt_d = ((state_q == DOOR) && (state_d == DOOR)) ? dwellCnt_q + DOOR_W'(1) : '0;
        clrEn      = (state_q == DOOR) || (state_d == DOOR);
    end

    // State, direction, floor and dwell registers.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q    <= IDLE;
            dir_q      <= DIR_UP;
            floor_q    <= '0;
            dwellCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            floor_q    <= floor_d;
            dwellCnt_q <= dwellCnt_d;
        end
    end

    // Output decode from the upcoming state so registered commands track state_q exactly.
    always_comb begin
        goUp_d   = (state_d == MOVE_UP);
        goDown_d = (state_d == MOVE_DOWN);
        halt_d   = !((state_d == MOVE_UP) || (state_d == MOVE_DOWN));
        door_d   = (state_d == DOOR);
        fault_d  = (state_d == FAULT);
    end

    // Command output flops.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            goUp_q   <= 1'b0;
            goDown_q <= 1'b0;
            halt_q   <= 1'b1;
            door_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            goUp_q   <= goUp_d;
            goDown_q <= goDown_d;
            halt_q   <= halt_d;
            door_q   <= door_d;
            fault_q  <= fault_d;
        end
    end

    assign go_up     = goUp_q;
    assign go_down   = goDown_q;
    assign halt      = halt_q;
    assign door_open = door_q;
    assign fault     = fault_q;
    assign cur_floor = floor_q;
    assign pending   = pendingVec;

endmodule

// File: tb/tb_ascensor_dispatcher.sv
// Self-checking bench for ascensor_dispatcher: directed scenarios plus a
// randomized run, all compared against a behavioural cabin model.
module tb_ascensor_dispatcher;

    localparam int NF = 8;
    localparam int DC = 4;
    localparam int M_IDLE  = 0;
    localparam int M_UP    = 1;
    localparam int M_DOWN  = 2;
    localparam int M_DOOR  = 3;
    localparam int M_FAULT = 4;
    localparam logic [15:0] RESET_VEC = 16'h2000;

    logic           CLK = 1'b0;
    logic           RESET_L;
    logic [NF-1:0]  call_req;
    logic           floor_tick;
    logic           top_lim;
    logic           bott_lim;
    logic           go_up;
    logic           go_down;
    logic           halt;
    logic           door_open;
    logic [2:0]     cur_floor;
    logic [NF-1:0]  pending;
    logic           fault;

    int checks = 0;
    int errors = 0;

    int        mFloor;
    bit [7:0]  mPend;
    int        mMode;
    bit        mDirUp;
    int        mDoorLeft;

    ascensor_dispatcher #(
        .N_FLOORS    (NF),
        .FLOOR_W     (3),
        .DOOR_CYCLES (DC),
        .DOOR_W      (3)
    ) dut (
        .CLK        (CLK),
        .RESET_L    (RESET_L),
        .call_req   (call_req),
        .floor_tick (floor_tick),
        .top_lim    (top_lim),
        .bott_lim   (bott_lim),
        .go_up      (go_up),
        .go_down    (go_down),
        .halt       (halt),
        .door_open  (door_open),
        .cur_floor  (cur_floor),
        .pending    (pending),
        .fault      (fault)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] dutVec();
        return {go_up, go_down, halt, door_open, fault, cur_floor, pending};
    endfunction

    function automatic logic [15:0] modelVec();
        logic isUp, isDown;
        isUp   = (mMode == M_UP);
        isDown = (mMode == M_DOWN);
        return {isUp, isDown, !(isUp || isDown), mMode == M_DOOR, mMode == M_FAULT, 3'(mFloor), mPend};
    endfunction

    // SCAN rule over the request set, ignoring the floor the cabin is on.
    function automatic int pickMode(bit dirUp, bit [7:0] p, int f);
        bit ab = 0;
        bit be = 0;
        for (int i = 0; i < NF; i++) begin
            if (p[i] && i > f) ab = 1;
            if (p[i] && i < f) be = 1;
        end
        if (dirUp) return ab ? M_UP : (be ? M_DOWN : M_IDLE);
        return be ? M_DOWN : (ab ? M_UP : M_IDLE);
    endfunction

    task automatic modelReset();
        mFloor = 0; mPend = '0; mMode = M_IDLE; mDirUp = 1; mDoorLeft = 0;
    endtask

    task automatic modelStep();
        bit [7:0] pw;
        int nFloor, nMode, nf;
        pw = mPend | call_req;
        nFloor = mFloor;
        if (mMode == M_UP && floor_tick)   nFloor = (mFloor < NF-1) ? mFloor + 1 : NF-1;
        if (mMode == M_DOWN && floor_tick) nFloor = (mFloor > 0) ? mFloor - 1 : 0;
        if (top_lim)  nFloor = NF-1;
        if (bott_lim) nFloor = 0;
        nMode = mMode;
        case (mMode)
            M_IDLE: nMode = mPend[mFloor] ? M_DOOR : pickMode(mDirUp, mPend, mFloor);
            M_UP: begin
                if (top_lim) nMode = M_DOOR;
                else if (floor_tick) begin
                    nf = (mFloor < NF-1) ? mFloor + 1 : NF-1;
                    if (pw[nf] || nf == NF-1) nMode = M_DOOR;
                end
            end
            M_DOWN: begin
                if (bott_lim) nMode = M_DOOR;
                else if (floor_tick) begin
                    nf = (mFloor > 0) ? mFloor - 1 : 0;
                    if (pw[nf] || nf == 0) nMode = M_DOOR;
                end
            end
            M_DOOR: begin
                if (mDoorLeft > 1) mDoorLeft = mDoorLeft - 1;
                else nMode = pickMode(mDirUp, mPend, mFloor);
            end
            default: nMode = M_FAULT;
        endcase
        if ((top_lim && bott_lim) || (mMode == M_UP && floor_tick && top_lim) ||
            (mMode == M_DOWN && floor_tick && bott_lim)) nMode = M_FAULT;
        if (nMode == M_DOOR && mMode != M_DOOR) mDoorLeft = DC;
        if (nMode == M_UP)   mDirUp = 1;
        if (nMode == M_DOWN) mDirUp = 0;
        mPend = pw;
        if (nMode == M_DOOR || mMode == M_DOOR) mPend[nFloor] = 1'b0;
        mFloor = nFloor;
        mMode = nMode;
    endtask

    task automatic cycle();
        if (!RESET_L) modelReset();
        else modelStep();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RESET_L = 0; call_req = '0; floor_tick = 0; top_lim = 0; bott_lim = 0;
        modelReset();
        repeat (3) cycle();
        RESET_L = 1;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (dutVec() !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL reset_values: got %h expected %h", dutVec(), RESET_VEC);
        end
        for (int k = 0; k < 20; k++) begin
            cycle();
            checks++;
            if (dutVec() !== RESET_VEC) begin
                errors++;
                $display("[TB] FAIL reset_idle: cycle %0d got %h expected %h", k, dutVec(), RESET_VEC);
            end
        end
    endtask

    task automatic test_single_up();
        int floors[$];
        int doorCycles = 0;
        int lastFloor = 0;
        doReset();
        call_req = 8'h08;
        cycle();
        call_req = '0;
        checks++;
        if (pending !== 8'h08 || go_up !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_up_latch: got pending=%h go_up=%b expected 08/0", pending, go_up);
        end
        cycle();
        checks++;
        if (go_up !== 1'b1 || halt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_up_start: got go_up=%b halt=%b expected 1/0", go_up, halt);
        end
        for (int k = 0; k < 80; k++) begin
            floor_tick = (k % 5 == 4);
            cycle();
            checks++;
            if (dutVec() !== modelVec()) begin
                errors++;
                $display("[TB] FAIL single_up_model: got %h expected %h", dutVec(), modelVec());
            end
            if (door_open) doorCycles++;
            if (int'(cur_floor) != lastFloor) begin
                floors.push_back(int'(cur_floor));
                lastFloor = int'(cur_floor);
            end
        end
        floor_tick = 0;
        checks++;
        if (floors.size() != 3 || floors[0] != 1 || floors[1] != 2 || floors[2] != 3) begin
            errors++;
            $display("[TB] FAIL single_up_floors: got %0d floor changes ending at %0d expected 1,2,3", floors.size(), lastFloor);
        end
        checks++;
        if (doorCycles != DC) begin
            errors++;
            $display("[TB] FAIL single_up_dwell: got %0d door cycles expected %0d", doorCycles, DC);
        end
        checks++;
        if ({pending, halt, go_up, go_down, door_open} !== {8'h00, 4'b1000}) begin
            errors++;
            $display("[TB] FAIL single_up_end: got pending=%h halt=%b up=%b down=%b door=%b expected 00 1 0 0 0",
                     pending, halt, go_up, go_down, door_open);
        end
    endtask

    task automatic test_scan();
        int visits[$];
        int lengths[$];
        int run = 0;
        bit injected = 0;
        doReset();
        call_req = 8'h20;
        cycle();
        call_req = '0;
        for (int k = 0; k < 200; k++) begin
            floor_tick = (k % 3 == 2);
            if (!injected && go_up && cur_floor == 3'd2) begin
                call_req = 8'h01;
                injected = 1;
            end else begin
                call_req = '0;
            end
            cycle();
            checks++;
            if (dutVec() !== modelVec()) begin
                errors++;
                $display("[TB] FAIL scan_model: got %h expected %h", dutVec(), modelVec());
            end
            if (door_open) begin
                if (run == 0) visits.push_back(int'(cur_floor));
                run++;
            end else if (run != 0) begin
                lengths.push_back(run);
                run = 0;
            end
        end
        floor_tick = 0; call_req = '0;
        checks++;
        if (visits.size() != 2 || visits[0] != 5 || visits[1] != 0) begin
            errors++;
            $display("[TB] FAIL scan_order: got %0d stops (first %0d) expected stops 5 then 0",
                     visits.size(), (visits.size() > 0) ? visits[0] : -1);
        end
        checks++;
        if (lengths.size() != 2 || lengths[0] != DC || lengths[1] != DC) begin
            errors++;
            $display("[TB] FAIL scan_dwell: got %0d dwells (first %0d) expected two of %0d",
                     lengths.size(), (lengths.size() > 0) ? lengths[0] : -1, DC);
        end
    endtask

    task automatic test_call_during_door();
        int doorCycles = 0;
        int doorRuns = 0;
        int run = 0;
        bit prevDoor = 0;
        bit injected = 0;
        bit inj;
        doReset();
        call_req = 8'h04;
        cycle();
        call_req = '0;
        for (int k = 0; k < 80; k++) begin
            floor_tick = (k % 4 == 3);
            inj = door_open && run == 2 && !injected;
            call_req = inj ? 8'h04 : 8'h00;
            if (inj) injected = 1;
            cycle();
            checks++;
            if (dutVec() !== modelVec()) begin
                errors++;
                $display("[TB] FAIL door_call_model: got %h expected %h", dutVec(), modelVec());
            end
            if (inj) begin
                checks++;
                if (pending[2] !== 1'b0 || door_open !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL door_call_clear: got pending[2]=%b door=%b expected 0/1", pending[2], door_open);
                end
            end
            if (door_open) begin
                doorCycles++;
                if (!prevDoor) doorRuns++;
                run++;
            end else begin
                run = 0;
            end
            prevDoor = door_open;
        end
        floor_tick = 0; call_req = '0;
        checks++;
        if (doorCycles != DC || doorRuns != 1 || !injected || pending !== 8'h00) begin
            errors++;
            $display("[TB] FAIL door_call_dwell: got cycles=%0d opens=%0d injected=%0d pending=%h expected %0d 1 1 00",
                     doorCycles, doorRuns, injected, pending, DC);
        end
    endtask

    task automatic test_limit_resync();
        bit injected = 0;
        bit resynced = 0;
        bit armed;
        doReset();
        call_req = 8'h10;
        cycle();
        call_req = '0;
        for (int k = 0; k < 150; k++) begin
            armed = !resynced && go_down && (cur_floor == 3'd3);
            bott_lim = armed;
            floor_tick = !armed && (k % 3 == 2);
            if (door_open && !injected) begin
                call_req = 8'h01;
                injected = 1;
            end else begin
                call_req = '0;
            end
            cycle();
            checks++;
            if (dutVec() !== modelVec()) begin
                errors++;
                $display("[TB] FAIL resync_model: got %h expected %h", dutVec(), modelVec());
            end
            if (armed) begin
                resynced = 1;
                checks++;
                if ({cur_floor, door_open, halt, go_down} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL resync_floor: got floor=%0d door=%b halt=%b down=%b expected 0 1 1 0",
                             cur_floor, door_open, halt, go_down);
                end
            end
        end
        bott_lim = 0; floor_tick = 0; call_req = '0;
        checks++;
        if (!resynced) begin
            errors++;
            $display("[TB] FAIL resync_reached: got no descent through floor 3 expected one");
        end
    endtask

    task automatic test_fault();
        doReset();
        top_lim = 1; bott_lim = 1;
        cycle();
        top_lim = 0; bott_lim = 0;
        checks++;
        if (fault !== 1'b1 || halt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fault_both_limits: got fault=%b halt=%b expected 1/1", fault, halt);
        end
        for (int k = 0; k < 10; k++) begin
            call_req = 8'h01 << (k % NF);
            floor_tick = k[0];
            cycle();
            checks++;
            if (dutVec() !== modelVec() || fault !== 1'b1 || halt !== 1'b1) begin
                errors++;
                $display("[TB] FAIL fault_hold: got %h expected %h", dutVec(), modelVec());
            end
        end
        call_req = '0; floor_tick = 0;
        doReset();
        checks++;
        if (dutVec() !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL fault_cleared: got %h expected %h", dutVec(), RESET_VEC);
        end
        call_req = 8'h80;
        cycle();
        call_req = '0;
        cycle();
        top_lim = 1; floor_tick = 1;
        cycle();
        top_lim = 0; floor_tick = 0;
        checks++;
        if (fault !== 1'b1 || halt !== 1'b1 || go_up !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fault_tick_at_limit: got fault=%b halt=%b up=%b expected 1 1 0", fault, halt, go_up);
        end
    endtask

    task automatic test_async_reset();
        doReset();
        call_req = 8'h40;
        cycle();
        call_req = '0;
        cycle();
        floor_tick = 1;
        cycle();
        floor_tick = 0;
        checks++;
        if (go_up !== 1'b1 || cur_floor !== 3'd1) begin
            errors++;
            $display("[TB] FAIL async_pre_motion: got up=%b floor=%0d expected 1/1", go_up, cur_floor);
        end
        #2;
        RESET_L = 0;
        modelReset();
        #1;
        checks++;
        if (dutVec() !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h", dutVec(), RESET_VEC);
        end
        @(posedge CLK);
        #1;
        RESET_L = 1;
    endtask

    task automatic test_random();
        doReset();
        for (int k = 0; k < 3000; k++) begin
            call_req = ($urandom_range(0, 9) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            floor_tick = ($urandom_range(0, 3) == 0);
            cycle();
            checks++;
            if (dutVec() !== modelVec()) begin
                errors++;
                $display("[TB] FAIL random_model: cycle %0d got %h expected %h", k, dutVec(), modelVec());
            end
            checks++;
            if ((32'(go_up) + 32'(go_down) + 32'(halt)) != 1) begin
                errors++;
                $display("[TB] FAIL random_onehot: got up=%b down=%b halt=%b expected exactly one", go_up, go_down, halt);
            end
        end
        call_req = '0; floor_tick = 0;
    endtask

    initial begin
        RESET_L = 0; call_req = '0; floor_tick = 0; top_lim = 0; bott_lim = 0;
        modelReset();
        test_reset();
        test_single_up();
        test_scan();
        test_call_during_door();
        test_limit_resync();
        test_fault();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
